ttl_clocked_addressable_demux: RTL and testbench

- Parametrised, clocked successor to the dual decoder/demultiplexer family.
- BLOCKS independent channels share one address pointer. Each channel steers its data bit into one of WIDTH_OUT stored outputs, in one of three store modes.
- The shared address pointer can load an address or auto-scan with wrap-around. Outputs are registered with an optional active-low presentation.
- Sits beside the combinational decoder parts; used as a scanned output-select / addressable-latch array.

---
 rtl/ttl_clocked_addressable_demux_pkg.sv | 43 ++++
 rtl/ttl_addressable_demux_block.sv | 70 +++++++
 rtl/ttl_clocked_addressable_demux.sv | 103 ++++++++++
 tb/tb_ttl_clocked_addressable_demux.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_clocked_addressable_demux_pkg.sv
// ---------------------------------------------------------------------------
// ttl_clocked_addressable_demux_pkg
//
// Shared definitions for the clocked addressable demultiplexer:
//   mode_e     - store mode encoding carried on the Mode input
//   next_addr  - shared pointer advance rule, returns {wrap, next}
// ---------------------------------------------------------------------------
package ttl_clocked_addressable_demux_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_WRITE = 2'b01,
        MODE_DEMUX = 2'b10,
        MODE_SCAN  = 2'b11
    } mode_e;

    // Width of the address argument/result of next_addr. The function is
    // shared by every parametrisation, so it works on a fixed wide address
    // and callers cast down to their own pointer width.
    localparam int unsigned NEXT_ADDR_W = 32;

    // Pointer advance rule.
    //   scan = 0 : pointer simply takes the effective address, no wrap.
    //   scan = 1 : step by one; the last legal address, or any address past
    //              it (reachable only for non power-of-two widths), returns
    //              to zero and raises wrap.
    function automatic logic [NEXT_ADDR_W:0] next_addr(
        input logic [NEXT_ADDR_W-1:0] addr,
        input logic                   scan,
        input int unsigned            width_out
    );
        logic [NEXT_ADDR_W:0] res;
        if (!scan) begin
            res = {1'b0, addr};
        end else if (addr >= NEXT_ADDR_W'(width_out - 1)) begin
            res = {1'b1, {NEXT_ADDR_W{1'b0}}};
        end else begin
            res = {1'b0, addr + 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/ttl_addressable_demux_block.sv
// ---------------------------------------------------------------------------
// ttl_addressable_demux_block
//
// One channel of the addressable demultiplexer: WIDTH_OUT stored bits, one
// of which is addressed per clock edge.
//
// Ports:
//   Clk        in   rising-edge clock
//   Clear_bar  in   asynchronous active-low clear of all stored bits
//   Enable_bar in   active-low store enable for this channel
//   Mode       in   HOLD / WRITE / DEMUX / SCAN (see package)
//   addr       in   effective address chosen by the top level
//   D          in   data bit for this channel
//   store      out  stored bits, true polarity
// ---------------------------------------------------------------------------
module ttl_addressable_demux_block
    import ttl_clocked_addressable_demux_pkg::*;
#(
    parameter int WIDTH_OUT = 8,
    localparam int WIDTH_IN = $clog2(WIDTH_OUT)
) (
    input  logic                 Clk,
    input  logic                 Clear_bar,
    input  logic                 Enable_bar,
    input  logic [1:0]           Mode,
    input  logic [WIDTH_IN-1:0]  addr,
    input  logic                 D,
    output logic [WIDTH_OUT-1:0] store
);

    logic [WIDTH_OUT-1:0] store_d;
    logic [WIDTH_OUT-1:0] store_q;

    // Address matching is done bit-by-bit against every legal index, so an
    // out-of-range address simply matches nothing: WRITE/SCAN leave the
    // store untouched and DEMUX clears every bit.
    always_comb begin
        store_d = store_q;
        if (!Enable_bar) begin
            case (Mode)
                MODE_WRITE, MODE_SCAN: begin
                    for (int i = 0; i < WIDTH_OUT; i++) begin
                        if (addr == WIDTH_IN'(i)) begin
                            store_d[i] = D;
                        end
                    end
                end
                MODE_DEMUX: begin
                    for (int i = 0; i < WIDTH_OUT; i++) begin
                        store_d[i] = (addr == WIDTH_IN'(i)) ? D : 1'b0;
                    end
                end
                default: begin
                    store_d = store_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            store_q <= '0;
        end else begin
            store_q <= store_d;
        end
    end

    assign store = store_q;

endmodule

// File: rtl/ttl_clocked_addressable_demux.sv
// ---------------------------------------------------------------------------
// ttl_clocked_addressable_demux
//
// BLOCKS independent channels sharing one address pointer. Each channel
// steers its data bit into one of WIDTH_OUT stored outputs. The pointer can
// be loaded from A or auto-scan with wrap-around.
//
// Ports:
//   Clk        in   rising-edge clock
//   Clear_bar  in   asynchronous active-low reset (stores, pointer, Wrap)
//   Enable_bar in   [BLOCKS] per-channel store enable, active-low
//   Mode       in   [2] 00 HOLD, 01 WRITE, 10 DEMUX, 11 SCAN
//   Load       in   use A instead of the pointer as this edge's address
//   A          in   [WIDTH_IN] address
//   D          in   [BLOCKS] per-channel data bit
//   Addr_out   out  [WIDTH_IN] current pointer value
//   Wrap       out  one-cycle pulse after a SCAN edge that wrapped
//   Q_2D       out  [BLOCKS*WIDTH_OUT] stored outputs, channel b at
//                   [b*WIDTH_OUT +: WIDTH_OUT], inverted when INVERT_OUT=1
// ---------------------------------------------------------------------------
module ttl_clocked_addressable_demux
    import ttl_clocked_addressable_demux_pkg::*;
#(
    parameter int BLOCKS     = 2,
    parameter int WIDTH_OUT  = 8,
    parameter bit INVERT_OUT = 1'b1,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0,
    localparam int WIDTH_IN  = $clog2(WIDTH_OUT)
) (
    input  logic                        Clk,
    input  logic                        Clear_bar,
    input  logic [BLOCKS-1:0]           Enable_bar,
    input  logic [1:0]                  Mode,
    input  logic                        Load,
    input  logic [WIDTH_IN-1:0]         A,
    input  logic [BLOCKS-1:0]           D,
    output logic [WIDTH_IN-1:0]         Addr_out,
    output logic                        Wrap,
    output logic [BLOCKS*WIDTH_OUT-1:0] Q_2D
);

    // Parameter sanity. The rise/fall delays describe the board-level part
    // and are realised as zero in this synthesizable model; they are only
    // range-checked here.
    if (BLOCKS < 1) begin : g_chk_blocks
        $error("BLOCKS must be at least 1");
    end
    if (WIDTH_OUT < 2) begin : g_chk_width
        $error("WIDTH_OUT must be at least 2");
    end
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_chk_delay
        $error("DELAY_RISE/DELAY_FALL must be non-negative");
    end

    logic [WIDTH_IN-1:0]         addr_eff;
    logic [WIDTH_IN-1:0]         ptr_d;
    logic [WIDTH_IN-1:0]         ptr_q;
    logic                        wrap_d;
    logic                        wrap_q;
    logic                        scan;
    logic [BLOCKS*WIDTH_OUT-1:0] store_all;

    // Load overrides the pointer in every mode, HOLD included. The pointer
    // advances regardless of the channel enables.
    always_comb begin
        scan     = (Mode == MODE_SCAN);
        addr_eff = Load ? A : ptr_q;
        ptr_d    = WIDTH_IN'(next_addr(NEXT_ADDR_W'(addr_eff), scan, WIDTH_OUT));
        wrap_d   = 1'(next_addr(NEXT_ADDR_W'(addr_eff), scan, WIDTH_OUT) >> NEXT_ADDR_W);
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar b = 0; b < BLOCKS; b++) begin : g_block
        ttl_addressable_demux_block #(
            .WIDTH_OUT (WIDTH_OUT)
        ) u_block (
            .Clk        (Clk),
            .Clear_bar  (Clear_bar),
            .Enable_bar (Enable_bar[b]),
            .Mode       (Mode),
            .addr       (addr_eff),
            .D          (D[b]),
            .store      (store_all[b*WIDTH_OUT +: WIDTH_OUT])
        );
    end

    // Polarity is applied after the flops so a cleared store presents all
    // ones immediately when INVERT_OUT is set.
    assign Q_2D     = INVERT_OUT ? ~store_all : store_all;
    assign Addr_out = ptr_q;
    assign Wrap     = wrap_q;

endmodule

// File: tb/tb_ttl_clocked_addressable_demux.sv
module tb_ttl_clocked_addressable_demux;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] WR   = 2'b01;
    localparam logic [1:0] DMX  = 2'b10;
    localparam logic [1:0] SCN  = 2'b11;

    logic clk     = 1'b0;
    logic clk_run = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Main DUT: BLOCKS=2, WIDTH_OUT=8, INVERT_OUT=1
    logic        clr_n;
    logic [1:0]  en_b, mode, d;
    logic        load;
    logic [2:0]  a;
    logic [2:0]  addr_out;
    logic        wrap;
    logic [15:0] q;

    ttl_clocked_addressable_demux #(
        .BLOCKS(2), .WIDTH_OUT(8), .INVERT_OUT(1'b1)
    ) u_dut (
        .Clk(clk), .Clear_bar(clr_n), .Enable_bar(en_b), .Mode(mode),
        .Load(load), .A(a), .D(d), .Addr_out(addr_out), .Wrap(wrap), .Q_2D(q)
    );

    // True-polarity DUT
    logic        p_clr_n;
    logic [1:0]  p_en_b, p_mode, p_d;
    logic        p_load;
    logic [2:0]  p_a;
    logic [2:0]  p_addr;
    logic        p_wrap;
    logic [15:0] p_q;

    ttl_clocked_addressable_demux #(
        .BLOCKS(2), .WIDTH_OUT(8), .INVERT_OUT(1'b0)
    ) u_pos (
        .Clk(clk), .Clear_bar(p_clr_n), .Enable_bar(p_en_b), .Mode(p_mode),
        .Load(p_load), .A(p_a), .D(p_d), .Addr_out(p_addr), .Wrap(p_wrap), .Q_2D(p_q)
    );

    // Non power-of-two DUT: one channel of five outputs
    logic        n_clr_n;
    logic [0:0]  n_en_b, n_d;
    logic [1:0]  n_mode;
    logic        n_load;
    logic [2:0]  n_a;
    logic [2:0]  n_addr;
    logic        n_wrap;
    logic [4:0]  n_q;

    ttl_clocked_addressable_demux #(
        .BLOCKS(1), .WIDTH_OUT(5), .INVERT_OUT(1'b0)
    ) u_np (
        .Clk(clk), .Clear_bar(n_clr_n), .Enable_bar(n_en_b), .Mode(n_mode),
        .Load(n_load), .A(n_a), .D(n_d), .Addr_out(n_addr), .Wrap(n_wrap), .Q_2D(n_q)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  en_b;
        logic [1:0]  mode;
        logic        load;
        logic [2:0]  a;
        logic [1:0]  d;
        logic [15:0] q;
        logic [2:0]  addr;
        logic        wrap;
        string       tag;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [2:0]  addr;
        logic        wrap;
        string       tag;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Drive one vector on the falling edge, queue its expectation, and
    // check the queue head just after the following rising edge.
    task automatic apply(input logic [1:0] ie, input logic [1:0] im, input logic il,
                         input logic [2:0] ia, input logic [1:0] id, input exp_t e);
        exp_t want;
        @(negedge clk);
        en_b = ie; mode = im; load = il; a = ia; d = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({e.tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            want = sb.pop_front();
            chk({want.tag, ".q"},    32'(q),        32'(want.q));
            chk({want.tag, ".addr"}, 32'(addr_out), 32'(want.addr));
            chk({want.tag, ".wrap"}, 32'(wrap),     32'(want.wrap));
        end
    endtask

    task automatic pos_step(input logic [1:0] ie, input logic [1:0] im, input logic il,
                            input logic [2:0] ia, input logic [1:0] id,
                            input logic [15:0] eq, input logic [2:0] ea, input logic ew,
                            input string tag);
        @(negedge clk);
        p_en_b = ie; p_mode = im; p_load = il; p_a = ia; p_d = id;
        @(posedge clk);
        #1;
        chk({tag, ".q"},    32'(p_q),    32'(eq));
        chk({tag, ".addr"}, 32'(p_addr), 32'(ea));
        chk({tag, ".wrap"}, 32'(p_wrap), 32'(ew));
    endtask

    task automatic np_step(input logic ie, input logic [1:0] im, input logic il,
                           input logic [2:0] ia, input logic id,
                           input logic [4:0] eq, input logic [2:0] ea, input logic ew,
                           input string tag);
        @(negedge clk);
        n_en_b = ie; n_mode = im; n_load = il; n_a = ia; n_d = id;
        @(posedge clk);
        #1;
        chk({tag, ".q"},    32'(n_q),    32'(eq));
        chk({tag, ".addr"}, 32'(n_addr), 32'(ea));
        chk({tag, ".wrap"}, 32'(n_wrap), 32'(ew));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ms [2];
        logic [2:0] mptr, aeff;
        logic       mwrap;
        logic [1:0] ie, im, id;
        logic       il;
        logic [2:0] ia;
        exp_t       e;

        tbl[0]  = '{2'b00, HOLD, 1'b0, 3'd5, 2'b11, 16'hFFFF, 3'd0, 1'b0, "hold0"};
        tbl[1]  = '{2'b00, HOLD, 1'b0, 3'd2, 2'b01, 16'hFFFF, 3'd0, 1'b0, "hold1"};
        tbl[2]  = '{2'b11, HOLD, 1'b0, 3'd7, 2'b10, 16'hFFFF, 3'd0, 1'b0, "hold2"};
        tbl[3]  = '{2'b00, HOLD, 1'b0, 3'd1, 2'b00, 16'hFFFF, 3'd0, 1'b0, "hold3"};
        tbl[4]  = '{2'b00, WR,   1'b1, 3'd3, 2'b11, 16'hF7F7, 3'd3, 1'b0, "wr_load"};
        tbl[5]  = '{2'b00, WR,   1'b0, 3'd6, 2'b10, 16'hF7FF, 3'd3, 1'b0, "wr_ptr"};
        tbl[6]  = '{2'b10, DMX,  1'b1, 3'd5, 2'b01, 16'hF7DF, 3'd5, 1'b0, "demux"};
        tbl[7]  = '{2'b00, SCN,  1'b1, 3'd6, 2'b11, 16'hB79F, 3'd7, 1'b0, "scan1"};
        tbl[8]  = '{2'b00, SCN,  1'b0, 3'd2, 2'b11, 16'h371F, 3'd0, 1'b1, "scan2"};
        tbl[9]  = '{2'b00, SCN,  1'b0, 3'd4, 2'b11, 16'h361E, 3'd1, 1'b0, "scan3"};
        tbl[10] = '{2'b00, SCN,  1'b1, 3'd7, 2'b00, 16'hB69E, 3'd0, 1'b1, "scan4"};

        clr_n = 1'b0; p_clr_n = 1'b0; n_clr_n = 1'b0;
        en_b = 2'b00; mode = HOLD; load = 1'b0; a = 3'd0; d = 2'b00;
        p_en_b = 2'b00; p_mode = HOLD; p_load = 1'b0; p_a = 3'd0; p_d = 2'b00;
        n_en_b = 1'b0; n_mode = HOLD; n_load = 1'b0; n_a = 3'd0; n_d = 1'b0;

        // Reset with no clock running
        #3;
        chk("rst.q",      32'(q),        32'hFFFF);
        chk("rst.addr",   32'(addr_out), 32'd0);
        chk("rst.wrap",   32'(wrap),     32'd0);
        chk("rst_pos.q",  32'(p_q),      32'h0000);
        chk("rst_np.q",   32'(n_q),      32'h00);
        #1;
        clr_n = 1'b1; p_clr_n = 1'b1; n_clr_n = 1'b1;
        clk_run = 1'b1;

        for (int i = 0; i < 11; i++) begin
            e = '{tbl[i].q, tbl[i].addr, tbl[i].wrap, tbl[i].tag};
            apply(tbl[i].en_b, tbl[i].mode, tbl[i].load, tbl[i].a, tbl[i].d, e);
        end

        // Asynchronous clear between edges while Wrap is high
        clr_n = 1'b0;
        #1;
        chk("midrst.q",    32'(q),        32'hFFFF);
        chk("midrst.addr", 32'(addr_out), 32'd0);
        chk("midrst.wrap", 32'(wrap),     32'd0);
        #2;
        clr_n = 1'b1;
        apply(2'b00, SCN, 1'b0, 3'd5, 2'b01, '{16'hFFFE, 3'd1, 1'b0, "post_rst"});

        // Randomised traffic against a behavioural model
        ms[0] = 8'h01; ms[1] = 8'h00; mptr = 3'd1; mwrap = 1'b0;
        for (int n = 0; n < 48; n++) begin
            ie = 2'($urandom_range(0, 3));
            im = 2'($urandom_range(0, 3));
            il = 1'($urandom_range(0, 1));
            ia = 3'($urandom_range(0, 7));
            id = 2'($urandom_range(0, 3));
            aeff = il ? ia : mptr;
            for (int b = 0; b < 2; b++) begin
                if (!ie[b]) begin
                    if (im == DMX) ms[b] = 8'h00;
                    if (im != HOLD) ms[b][aeff] = id[b];
                end
            end
            mwrap = (im == SCN) && (aeff == 3'd7);
            mptr  = (im == SCN) ? aeff + 3'd1 : aeff;
            e = '{~{ms[1], ms[0]}, mptr, mwrap, $sformatf("rand%0d", n)};
            apply(ie, im, il, ia, id, e);
        end

        // True polarity
        @(negedge clk);
        p_clr_n = 1'b0;
        #1;
        chk("pos_rst.q",    32'(p_q),    32'h0000);
        chk("pos_rst.addr", 32'(p_addr), 32'd0);
        p_clr_n = 1'b1;
        pos_step(2'b00, DMX,  1'b1, 3'd7, 2'b11, 16'h8080, 3'd7, 1'b0, "pos_demux");
        pos_step(2'b00, SCN,  1'b0, 3'd0, 2'b11, 16'h8080, 3'd0, 1'b1, "pos_wrap");
        pos_step(2'b00, HOLD, 1'b0, 3'd0, 2'b00, 16'h8080, 3'd0, 1'b0, "pos_hold");
        pos_step(2'b00, SCN,  1'b1, 3'd7, 2'b01, 16'h0080, 3'd0, 1'b1, "pos_rewrite");

        // Non power-of-two width, out-of-range addresses
        np_step(1'b0, WR,  1'b1, 3'd2, 1'b1, 5'h04, 3'd2, 1'b0, "np_wr");
        np_step(1'b0, WR,  1'b1, 3'd6, 1'b1, 5'h04, 3'd6, 1'b0, "np_wr_oor");
        np_step(1'b0, SCN, 1'b0, 3'd0, 1'b1, 5'h04, 3'd0, 1'b1, "np_scan_oor");
        np_step(1'b0, SCN, 1'b1, 3'd4, 1'b1, 5'h14, 3'd0, 1'b1, "np_scan_last");
        np_step(1'b0, SCN, 1'b0, 3'd0, 1'b1, 5'h15, 3'd1, 1'b0, "np_scan0");
        np_step(1'b0, DMX, 1'b1, 3'd7, 1'b1, 5'h00, 3'd7, 1'b0, "np_demux_oor");
        np_step(1'b1, WR,  1'b1, 3'd0, 1'b1, 5'h00, 3'd0, 1'b0, "np_disabled");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
